write_back: RTL and testbench

//  RV32I write-back stage: selects the register-file write data from the memory-access (MA) stage outputs.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_load_format.sv | 29 ++
 rtl/write_back.sv | 77 +++++++
 tb/tb_write_back.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the RV32I write-back stage.
// Load formatting is included only when WB_LOAD_EXT_EN is defined.
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    WB_SEL_RESULT = 2'd0,
    WB_SEL_PC4    = 2'd1,
    WB_SEL_RSVD   = 2'd2,
    WB_SEL_ZERO   = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_load_format.sv
// Aligns a raw data-memory word by byte offset and sign/zero-extends it per load funct3.
// Instantiated only when WB_LOAD_EXT_EN is defined.
module wb_load_format
  import wb_pkg::*;
(
  input  logic [31:0] read_data,
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Misaligned halfwords simply take the low half of the shifted word.
  assign shifted = read_data >> {byte_off, 3'b000};

  always_comb begin
    // NOTE: assign a default before the case so no path leaves load_data unassigned (latch).
    load_data = shifted;
    case (funct3)
      F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  load_data = {24'h0, shifted[7:0]};
      F3_LHU:  load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/write_back.sv
// RV32I write-back stage: combinational regfile write mux plus a one-cycle forward register.
// Define WB_LOAD_EXT_EN to enable byte/halfword load alignment and extension.
module write_back
  import wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ma_mem_to_reg,
  input  logic [1:0]        i_ma_rw_sel,
  input  logic [XLEN-1:0]   i_ma_result,
  input  logic [XLEN-1:0]   i_ma_read_data,
  input  logic [XLEN-1:0]   i_ma_pc_plus_4,
  input  logic [2:0]        i_ma_funct3,
  input  logic [1:0]        i_ma_byte_off,
  input  logic              i_ma_reg_write,
  input  logic [REG_AW-1:0] i_ma_rd,
  output logic [XLEN-1:0]   o_wb_data,
  output logic              o_wb_reg_write,
  output logic [REG_AW-1:0] o_wb_rd,
  output logic              o_wb_fwd_valid,
  output logic [REG_AW-1:0] o_wb_fwd_rd,
  output logic [XLEN-1:0]   o_wb_fwd_data
);

  logic [XLEN-1:0] load_data;
  wb_sel_e         sel;

`ifdef WB_LOAD_EXT_EN
  wb_load_format u_load_format (
    .read_data (i_ma_read_data),
    .funct3    (i_ma_funct3),
    .byte_off  (i_ma_byte_off),
    .load_data (load_data)
  );
`else
  logic unused_load_ctrl;
  assign unused_load_ctrl = ^{i_ma_funct3, i_ma_byte_off};
  assign load_data        = i_ma_read_data;
`endif

  assign sel = wb_sel_e'(i_ma_rw_sel);

  always_comb begin
    o_wb_data = '0;
    if (i_ma_mem_to_reg) begin
      o_wb_data = load_data;
    end else begin
      case (sel)
        WB_SEL_RESULT: o_wb_data = i_ma_result;
        WB_SEL_PC4:    o_wb_data = i_ma_pc_plus_4;
        WB_SEL_RSVD:   o_wb_data = i_ma_result;
        default:       o_wb_data = '0;
      endcase
    end
  end

  assign o_wb_rd        = i_ma_rd;
  assign o_wb_reg_write = i_ma_reg_write & (i_ma_rd != '0);

  // No stall input: the upstream MA register freezes its outputs instead.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_wb_fwd_valid <= 1'b0;
      o_wb_fwd_rd    <= '0;
      o_wb_fwd_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      o_wb_fwd_valid <= o_wb_reg_write;
      o_wb_fwd_rd    <= i_ma_rd;
      o_wb_fwd_data  <= o_wb_data;
    end
  end

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: select mux, x0 gating, forward registers, async reset, load formatting.
// Expected values come from a small reference model and are queued as stimulus is driven.
module tb_write_back;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_to_reg = 1'b0;
  logic [1:0]  rw_sel = 2'd0;
  logic [31:0] result = '0;
  logic [31:0] read_data = '0;
  logic [31:0] pc_plus_4 = '0;
  logic [2:0]  funct3 = '0;
  logic [1:0]  byte_off = '0;
  logic        reg_write = 1'b0;
  logic [4:0]  rd = '0;
  logic [31:0] wb_data;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } fwd_t;

  logic [31:0] data_q[$];
  fwd_t        fwd_q[$];

  write_back dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_ma_mem_to_reg (mem_to_reg),
    .i_ma_rw_sel     (rw_sel),
    .i_ma_result     (result),
    .i_ma_read_data  (read_data),
    .i_ma_pc_plus_4  (pc_plus_4),
    .i_ma_funct3     (funct3),
    .i_ma_byte_off   (byte_off),
    .i_ma_reg_write  (reg_write),
    .i_ma_rd         (rd),
    .o_wb_data       (wb_data),
    .o_wb_reg_write  (wb_reg_write),
    .o_wb_rd         (wb_rd),
    .o_wb_fwd_valid  (fwd_valid),
    .o_wb_fwd_rd     (fwd_rd),
    .o_wb_fwd_data   (fwd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_load(logic [31:0] rdata, logic [2:0] f3, logic [1:0] off);
`ifdef WB_LOAD_EXT_EN
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[off*8 +: 8];
    h = (off == 2'd0) ? rdata[15:0] : (off == 2'd1) ? rdata[23:8] :
        (off == 2'd2) ? rdata[31:16] : {8'h00, rdata[31:24]};
    if (f3 == 3'b000)      return {{24{b[7]}}, b};
    else if (f3 == 3'b100) return {24'h0, b};
    else if (f3 == 3'b001) return {{16{h[15]}}, h};
    else if (f3 == 3'b101) return {16'h0, h};
    else                   return rdata >> (8 * off);
`else
    return rdata + {29'd0, f3 & 3'b000} + {30'd0, off & 2'b00};
`endif
  endfunction

  function automatic logic [31:0] model_data();
    if (mem_to_reg) return model_load(read_data, funct3, byte_off);
    if (rw_sel == 2'd1) return pc_plus_4;
    if (rw_sel == 2'd3) return 32'h0;
    return result;
  endfunction

  // Push the expected combinational output and the forward value the next edge should capture.
  task automatic push_expect();
    fwd_t f;
    data_q.push_back(model_data());
    f.valid = reg_write && (rd != 5'd0);
    f.rd    = rd;
    f.data  = model_data();
    fwd_q.push_back(f);
  endtask

  task automatic check_comb(string name);
    logic [31:0] exp;
    exp = data_q.pop_front();
    tests_run++;
    if (wb_data !== exp) begin
      tests_failed++;
      $display("FAIL %s: o_wb_data got %h expected %h", name, wb_data, exp);
    end
  endtask

  task automatic check_fwd(string name);
    fwd_t f;
    f = fwd_q.pop_front();
    tests_run++;
    if (fwd_valid !== f.valid || fwd_rd !== f.rd || fwd_data !== f.data) begin
      tests_failed++;
      $display("FAIL %s: fwd got %b/%0d/%h expected %b/%0d/%h",
               name, fwd_valid, fwd_rd, fwd_data, f.valid, f.rd, f.data);
    end
  endtask

  task automatic test_reset();
    read_data = 32'h1234_5678;
    mem_to_reg = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (fwd_valid !== 1'b0 || fwd_rd !== 5'd0 || fwd_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_fwd: got %b/%0d/%h expected 0/0/00000000", fwd_valid, fwd_rd, fwd_data);
    end
    push_expect();
    fwd_q.delete();
    check_comb("reset_comb");
    @(negedge clk);
    rst = 1'b0;
    mem_to_reg = 1'b0;
  endtask

  task automatic test_select();
    read_data = 32'hAAAA_AAAA;
    result    = 32'hBBBB_BBBB;
    pc_plus_4 = 32'hCCCC_CCCC;
    reg_write = 1'b0;
    rd        = 5'd0;
    for (int m = 0; m < 2; m++) begin
      for (int s = 0; s < 4; s++) begin
        @(negedge clk);
        mem_to_reg = m[0];
        rw_sel     = s[1:0];
        push_expect();
        fwd_q.delete();
        #1 check_comb($sformatf("select_m%0d_s%0d", m, s));
      end
    end
    tests_run++;
    if (data_q.size() != 0) begin
      tests_failed++;
      $display("FAIL select_queue: %0d entries left, expected 0", data_q.size());
    end
  endtask

  task automatic test_x0_gate();
    mem_to_reg = 1'b0;
    rw_sel     = 2'd0;
    result     = 32'hBBBB_BBBB;
    // rd=0 write is suppressed; rd=5 write goes through; reg_write=0 never writes.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      reg_write = (i != 2);
      rd        = (i == 0) ? 5'd0 : 5'd5;
      push_expect();
      #1;
      tests_run++;
      if (wb_reg_write !== (i == 1) || wb_rd !== rd) begin
        tests_failed++;
        $display("FAIL x0_gate_%0d: we/rd got %b/%0d expected %b/%0d", i, wb_reg_write, wb_rd, (i == 1), rd);
      end
      check_comb($sformatf("x0_gate_data_%0d", i));
      @(posedge clk);
      #1 check_fwd($sformatf("x0_gate_fwd_%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_to_reg = $urandom_range(0, 1);
      rw_sel     = 2'($urandom_range(0, 3));
      result     = $urandom;
      read_data  = $urandom;
      pc_plus_4  = $urandom;
      funct3     = 3'($urandom_range(0, 7));
      byte_off   = 2'($urandom_range(0, 3));
      reg_write  = $urandom_range(0, 1);
      rd         = 5'($urandom_range(0, 31));
      push_expect();
      #1 check_comb($sformatf("b2b_data_%0d", i));
      @(posedge clk);
      #1 check_fwd($sformatf("b2b_fwd_%0d", i));
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    mem_to_reg = 1'b0;
    rw_sel     = 2'd0;
    result     = 32'hDEAD_BEEF;
    reg_write  = 1'b1;
    rd         = 5'd7;
    push_expect();
    data_q.delete();
    @(posedge clk);
    #1 check_fwd("async_pre");
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (fwd_valid !== 1'b0 || fwd_rd !== 5'd0 || fwd_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL async_reset: got %b/%0d/%h expected 0/0/00000000", fwd_valid, fwd_rd, fwd_data);
    end
    rw_sel = 2'd1;
    pc_plus_4 = 32'h0000_1004;
    push_expect();
    fwd_q.delete();
    #1 check_comb("async_comb_follow");
    @(negedge clk);
    rst = 1'b0;
    push_expect();
    data_q.delete();
    @(posedge clk);
    #1 check_fwd("async_release");
  endtask

  task automatic test_load_ext();
    logic [2:0] f3_tab  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0] off_tab [5] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd0};
    logic [31:0] want   [5];
`ifdef WB_LOAD_EXT_EN
    want = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8000, 32'h0000_FF80, 32'h8000_FF80};
`else
    want = '{32'h8000_FF80, 32'h8000_FF80, 32'h8000_FF80, 32'h8000_FF80, 32'h8000_FF80};
`endif
    mem_to_reg = 1'b1;
    read_data  = 32'h8000_FF80;
    reg_write  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      funct3   = f3_tab[i];
      byte_off = off_tab[i];
      rw_sel   = 2'(i);
      data_q.push_back(want[i]);
      #1 check_comb($sformatf("load_f3_%0d_off%0d", f3_tab[i], off_tab[i]));
    end
  endtask

  initial begin
    test_reset();
    test_select();
    test_x0_gate();
    test_back_to_back();
    test_async_reset();
    test_load_ext();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
